// File: rtl/reg_writeback_unit.sv
// reg_writeback_unit
//   Producer side of the register file write port. It holds one buffered ALU
//   result and one buffered load result, and drives the single we/waddr/wdata
//   write port from whichever entry wins a fixed load-first arbitration.
//   It also keeps a pending-write scoreboard so that issue logic can stall on
//   registers that still have a load outstanding.
//
//   Optional feature macro: WB_BYPASS_EN
//     defined   -> the write in flight is forwarded on byp_hitN/byp_dataN,
//                  and busyN drops in the writeback cycle itself.
//     undefined -> byp_* are tied to 0, and busyN drops the cycle after the write.
//
//   The reset is asynchronous and active-low. It empties both buffers and the
//   scoreboard immediately, so any in-flight result is dropped.

module reg_writeback_unit #(
    parameter int NREGS = 32,
    parameter int AW    = 6,
    parameter int DW    = 32
) (
    input  logic          clk,
    input  logic          rst_n,

    input  logic          alu_valid,
    output logic          alu_ready,
    input  logic [AW-1:0] alu_rd,
    input  logic [DW-1:0] alu_data,

    input  logic          ld_valid,
    output logic          ld_ready,
    input  logic [AW-1:0] ld_rd,
    input  logic [DW-1:0] ld_data,

    input  logic          issue_valid,
    input  logic [AW-1:0] issue_rd,

    input  logic [AW-1:0] raddr1,
    input  logic [AW-1:0] raddr2,
    output logic          busy1,
    output logic          busy2,
    output logic          byp_hit1,
    output logic          byp_hit2,
    output logic [DW-1:0] byp_data1,
    output logic [DW-1:0] byp_data2,

    output logic          we,
    output logic [AW-1:0] waddr,
    output logic [DW-1:0] wdata,
    output logic          wb_idle
);

    // Register index width. Address bits above it are ignored on input and
    // driven to zero on waddr.
    localparam int IW = $clog2(NREGS);

    // ------------------------------------------------------------------
    // Result buffers (one entry per source)
    // ------------------------------------------------------------------
    logic          alu_full_reg;
    logic [IW-1:0] alu_rd_reg;
    logic [DW-1:0] alu_data_reg;

    logic          ld_full_reg;
    logic [IW-1:0] ld_rd_reg;
    logic [DW-1:0] ld_data_reg;

    logic          alu_grant;
    logic          ld_grant;
    logic          alu_accept;
    logic          ld_accept;

    // Load results always win. The ALU entry only drains when no load is
    // buffered, so a continuous load stream starves the ALU by design.
    always_comb begin
        ld_grant  = ld_full_reg;
        alu_grant = alu_full_reg && !ld_full_reg;
    end

    // An entry can take a new result when it is empty or draining this
    // cycle. This sustains one result per cycle from a single source.
    always_comb begin
        alu_ready  = !alu_full_reg || alu_grant;
        ld_ready   = !ld_full_reg  || ld_grant;
        alu_accept = alu_valid && alu_ready;
        ld_accept  = ld_valid  && ld_ready;
    end

    // ALU buffer: fill on accept, otherwise empty once granted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alu_full_reg <= 1'b0;
            alu_rd_reg   <= '0;
            alu_data_reg <= '0;
        end else if (alu_accept) begin
            alu_full_reg <= 1'b1;
            alu_rd_reg   <= alu_rd[IW-1:0];
            alu_data_reg <= alu_data;
        end else if (alu_grant) begin
            alu_full_reg <= 1'b0;
        end
    end

    // Load buffer: fill on accept, otherwise empty once granted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ld_full_reg <= 1'b0;
            ld_rd_reg   <= '0;
            ld_data_reg <= '0;
        end else if (ld_accept) begin
            ld_full_reg <= 1'b1;
            ld_rd_reg   <= ld_rd[IW-1:0];
            ld_data_reg <= ld_data;
        end else if (ld_grant) begin
            ld_full_reg <= 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Write port
    // ------------------------------------------------------------------
    // Drive the write port straight from the granted entry. A result aimed at
    // x0 still wins its grant so that it drains, but it never raises we.
    always_comb begin
        we    = 1'b0;
        waddr = '0;
        wdata = '0;
        if (ld_grant) begin
            we    = (ld_rd_reg != '0);
            waddr = {{(AW-IW){1'b0}}, ld_rd_reg};
            wdata = ld_data_reg;
        end else if (alu_grant) begin
            we    = (alu_rd_reg != '0);
            waddr = {{(AW-IW){1'b0}}, alu_rd_reg};
            wdata = alu_data_reg;
        end
    end

    // ------------------------------------------------------------------
    // Pending-write scoreboard
    // ------------------------------------------------------------------
    // x0 is never pending. Bit 0 exists only in pending_vec, which makes the
    // lookup a plain index.
    logic [NREGS-1:1] pending_reg;
    logic [NREGS-1:1] pending_next;
    logic [NREGS-1:0] pending_vec;

    // Per-register next state. A new issue overrides a write completing in
    // the same cycle, so the later load stays tracked.
    generate
        for (genvar gi = 1; gi < NREGS; gi++) begin : g_pending
            localparam logic [IW-1:0] IDX = IW'(gi);
            logic set_hit;
            logic clr_hit;
            assign set_hit          = issue_valid && (issue_rd[IW-1:0] == IDX);
            assign clr_hit          = we && (waddr[IW-1:0] == IDX);
            assign pending_next[gi] = set_hit || (pending_reg[gi] && !clr_hit);
        end
    endgenerate

    // Scoreboard state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending_reg <= '0;
        end else begin
            pending_reg <= pending_next;
        end
    end

    assign pending_vec = {pending_reg, 1'b0};

    // ------------------------------------------------------------------
    // Scoreboard queries and optional bypass
    // ------------------------------------------------------------------
`ifdef WB_BYPASS_EN
    // Forward the write in flight. A register being written this cycle is no
    // longer reported busy, because its value is available on byp_data.
    always_comb begin
        byp_hit1  = we && (waddr[IW-1:0] == raddr1[IW-1:0]);
        byp_hit2  = we && (waddr[IW-1:0] == raddr2[IW-1:0]);
        byp_data1 = wdata;
        byp_data2 = wdata;
        busy1     = pending_vec[raddr1[IW-1:0]] && !byp_hit1;
        busy2     = pending_vec[raddr2[IW-1:0]] && !byp_hit2;
    end
`else
    // No forwarding: busy clears only once the register file holds the value.
    always_comb begin
        byp_hit1  = 1'b0;
        byp_hit2  = 1'b0;
        byp_data1 = '0;
        byp_data2 = '0;
        busy1     = pending_vec[raddr1[IW-1:0]];
        busy2     = pending_vec[raddr2[IW-1:0]];
    end
`endif

    // Idle when nothing is buffered and no load is outstanding.
    always_comb begin
        wb_idle = !alu_full_reg && !ld_full_reg && (pending_reg == '0);
    end

    // Upper address bits are deliberately ignored.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{alu_rd[AW-1:IW], ld_rd[AW-1:IW], issue_rd[AW-1:IW],
                                raddr1[AW-1:IW], raddr2[AW-1:IW]};

endmodule
